// File: rtl/mda_lcd_pkg.sv
// -----------------------------------------------------------------------------
// mda_lcd_pkg -- shared types and constants for the HD44780-style LCD writer.
//
// Contents:
//   lcd_state_e   : writer FSM state encoding (also driven on the debug port)
//   CNT_W         : width of the single shared down-counter
//   *_DEF         : default timing constants in clk cycles at 50 MHz
//   CMD_*         : instruction codes that need the long settle time
//   init_byte()   : 4-entry power-up init table (used when MDA_LCD_INIT_EN
//                   is defined in the build)
// -----------------------------------------------------------------------------
package mda_lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP = 3'd0,
    ST_INIT  = 3'd1,
    ST_IDLE  = 3'd2,
    ST_SETUP = 3'd3,
    ST_PULSE = 3'd4,
    ST_HOLD  = 3'd5,
    ST_WAIT  = 3'd6
  } lcd_state_e;

  localparam int CNT_W = 20;

  localparam int T_SETUP_DEF = 2;
  localparam int T_EN_DEF    = 12;
  localparam int T_HOLD_DEF  = 2;
  localparam int T_CMD_DEF   = 2000;    // 40 us
  localparam int T_SLOW_DEF  = 82000;   // 1.64 ms
  localparam int T_PWR_DEF   = 750000;  // 15 ms

  // Clear display and the two return-home encodings settle slowly.
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT = 8'h03;

  localparam int INIT_LEN = 4;

  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME) || (data == CMD_HOME_ALT));
  endfunction

  // 8-bit bus, 2 lines; display on; clear; entry mode increment.
  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = 8'h38;
      2'd1:    b = 8'h0C;
      2'd2:    b = 8'h01;
      default: b = 8'h06;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lcd_writer.sv
// -----------------------------------------------------------------------------
// lcd_writer -- writes single bytes to an HD44780-style character LCD.
//
// Optional feature: define MDA_LCD_INIT_EN to have the block send the init
// sequence 0x38, 0x0C, 0x01, 0x06 itself after the power-up wait. Without it
// the block goes straight to IDLE and software performs the init.
//
// Ports:
//   clk        : 50 MHz clock
//   reset_n    : asynchronous active-low reset
//   cmd_valid  : request to write one byte
//   cmd_rs     : 0 = instruction, 1 = character data
//   cmd_data   : byte to write
//   cmd_ready  : high only in IDLE; byte taken when cmd_valid & cmd_ready
//   init_done  : set on first entry to IDLE, cleared only by reset
//   LCD_EN     : enable strobe (registered)
//   LCD_RS     : register select (registered, held through the write)
//   LCD_RW     : constant 0, write-only
//   LCD_DATA   : data bus (registered, always driven)
//   dbg_state  : current FSM state, for observation only
//
// Handshake: cmd_valid/cmd_ready follow valid/ready semantics; a transfer
// happens on a rising clk edge where both are 1. Valid outside IDLE is
// ignored, so a requester holding valid loses nothing.
//
// Per byte: 1 accept cycle, T_SETUP, T_EN (LCD_EN=1), T_HOLD, then a settle
// wait of T_SLOW for clear/home instructions or T_CMD otherwise.
// -----------------------------------------------------------------------------
module lcd_writer
  import mda_lcd_pkg::*;
#(
  parameter int T_SETUP = T_SETUP_DEF,
  parameter int T_EN    = T_EN_DEF,
  parameter int T_HOLD  = T_HOLD_DEF,
  parameter int T_CMD   = T_CMD_DEF,
  parameter int T_SLOW  = T_SLOW_DEF,
  parameter int T_PWR   = T_PWR_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       init_done,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA,
  output lcd_state_e dbg_state
);

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             en_q, en_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             slow_q, slow_d;
`ifdef MDA_LCD_INIT_EN
  logic [1:0]       idx_q, idx_d;
  logic             init_run_q, init_run_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    data_d  = data_q;
    en_d    = en_q;
    ready_d = ready_q;
    done_d  = done_q;
    slow_d  = slow_q;
`ifdef MDA_LCD_INIT_EN
    idx_d      = idx_q;
    init_run_d = init_run_q;
`endif
    case (state_q)
      ST_PWRUP: begin
        // The counter comes out of reset at T_PWR and counts remaining
        // cycles including the current one, so PWRUP lasts exactly T_PWR.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d = '0;
`ifdef MDA_LCD_INIT_EN
          state_d    = ST_INIT;
          idx_d      = 2'd0;
          init_run_d = 1'b1;
`else
          state_d = ST_IDLE;
          ready_d = 1'b1;
          done_d  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef MDA_LCD_INIT_EN
      // Plays the role of the accept cycle for each table entry.
      ST_INIT: begin
        rs_d    = 1'b0;
        data_d  = init_byte(idx_q);
        slow_d  = is_slow_cmd(1'b0, init_byte(idx_q));
        state_d = ST_SETUP;
        cnt_d   = CNT_W'(T_SETUP - 1);
      end
`endif
      ST_IDLE: begin
        if (cmd_valid && ready_q) begin
          rs_d    = cmd_rs;
          data_d  = cmd_data;
          slow_d  = is_slow_cmd(cmd_rs, cmd_data);
          ready_d = 1'b0;
          state_d = ST_SETUP;
          cnt_d   = CNT_W'(T_SETUP - 1);
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_PULSE;
          cnt_d   = CNT_W'(T_EN - 1);
          en_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_W'(T_HOLD - 1);
          en_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_WAIT;
          cnt_d   = slow_q ? CNT_W'(T_SLOW - 1) : CNT_W'(T_CMD - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
`ifdef MDA_LCD_INIT_EN
          if (init_run_q && (idx_q != 2'(INIT_LEN - 1))) begin
            state_d = ST_INIT;
            idx_d   = idx_q + 2'd1;
          end else begin
            init_run_d = 1'b0;
            state_d    = ST_IDLE;
            ready_d    = 1'b1;
            done_d     = 1'b1;
          end
`else
          state_d = ST_IDLE;
          ready_d = 1'b1;
          done_d  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_PWRUP;
        cnt_d   = CNT_W'(T_PWR);
        en_d    = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_PWRUP;
      cnt_q   <= CNT_W'(T_PWR);
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      en_q    <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      slow_q  <= 1'b0;
`ifdef MDA_LCD_INIT_EN
      idx_q      <= 2'd0;
      init_run_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      en_q    <= en_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      slow_q  <= slow_d;
`ifdef MDA_LCD_INIT_EN
      idx_q      <= idx_d;
      init_run_q <= init_run_d;
`endif
    end
  end

  assign cmd_ready = ready_q;
  assign init_done = done_q;
  assign LCD_EN    = en_q;
  assign LCD_RS    = rs_q;
  assign LCD_RW    = 1'b0;
  assign LCD_DATA  = data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lcd_writer.sv
// -----------------------------------------------------------------------------
// tb_lcd_writer -- directed bench for lcd_writer with shortened settle times.
// Timing used: T_SETUP=2, T_EN=12, T_HOLD=2, T_CMD=30, T_SLOW=60, T_PWR=20.
// Accept-to-ready: 1+2+12+2+30 = 47 (normal), 1+2+12+2+60 = 77 (clear/home).
// Cycle n after accept is observed at the falling edge inside that cycle.
// -----------------------------------------------------------------------------
module tb_lcd_writer;
  import mda_lcd_pkg::*;

  localparam int LAT_N = 47;
  localparam int LAT_S = 77;
`ifdef MDA_LCD_INIT_EN
  localparam int PWR_RDY = 20 + 3 * 47 + 77;  // 238
`else
  localparam int PWR_RDY = 20;
`endif

  logic       clk;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       init_done;
  logic       LCD_EN;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [7:0] LCD_DATA;
  lcd_state_e dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];

  lcd_writer #(
    .T_SETUP(2), .T_EN(12), .T_HOLD(2), .T_CMD(30), .T_SLOW(60), .T_PWR(20)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_rs(cmd_rs),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready), .init_done(init_done),
    .LCD_EN(LCD_EN), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_en"},    32'(LCD_EN),    32'd0);
    check({tag, "_rs"},    32'(LCD_RS),    32'd0);
    check({tag, "_data"},  32'(LCD_DATA),  32'h00);
    check({tag, "_ready"}, 32'(cmd_ready), 32'd0);
    check({tag, "_done"},  32'(init_done), 32'd0);
    check({tag, "_rw"},    32'(LCD_RW),    32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_PWRUP));
  endtask

  // Call right after reset_n goes high at a falling edge.
  task automatic check_powerup(input string tag);
    int  first_rdy;
    bit  early;
    int  en_cyc;
    bit  prev_en;
    first_rdy = -1;
    early     = 1'b0;
    en_cyc    = 0;
    prev_en   = 1'b0;
`ifdef MDA_LCD_INIT_EN
    exp_q.push_back(8'h38);
    exp_q.push_back(8'h0C);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h06);
`endif
    for (int k = 1; k <= PWR_RDY + 50; k++) begin
      @(negedge clk);
      if (LCD_EN) begin
        en_cyc++;
        if (!prev_en) begin
          check({tag, "_init_rs"}, 32'(LCD_RS), 32'd0);
          if (exp_q.size() > 0) check({tag, "_init_data"}, 32'(LCD_DATA), 32'(exp_q.pop_front()));
          else check({tag, "_init_extra_pulse"}, 32'd1, 32'd0);
        end
      end
      prev_en = LCD_EN;
      if (cmd_ready || init_done) begin
        first_rdy = k;
        check({tag, "_done_with_ready"}, 32'(init_done), 32'(cmd_ready));
        break;
      end
      if (k < PWR_RDY - 1 && (cmd_ready !== 1'b0 || init_done !== 1'b0)) early = 1'b1;
    end
    check({tag, "_held_low"}, 32'(early), 32'd0);
    check({tag, "_ready_cycle"}, 32'(first_rdy), 32'(PWR_RDY));
    check({tag, "_en_cycles"}, 32'(en_cyc), 32'(48 * (PWR_RDY > 20 ? 1 : 0) / 4 * 4));
    check({tag, "_state_idle"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic wait_ready(input string tag);
    int t;
    t = 0;
    while (!cmd_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) check({tag, "_ready_timeout"}, 32'(cmd_ready), 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         exp_lat;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int    first_rdy, en_first, en_last, en_cnt;
    bit    held_ok;
    string tag;
    tag = $sformatf("vec%0d", idx);
    wait_ready(tag);
    cmd_valid = 1'b1;
    cmd_rs    = v.rs;
    cmd_data  = v.data;
    exp_q.push_back(v.data);
    first_rdy = -1; en_first = -1; en_last = -1; en_cnt = 0; held_ok = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check({tag, "_ready_drop"}, 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        cmd_rs    = ~v.rs;
        cmd_data  = ~v.data;
      end
      if (LCD_EN) begin
        en_cnt++;
        if (en_first < 0) begin
          en_first = n;
          check({tag, "_en_data"}, 32'(LCD_DATA), 32'(exp_q.pop_front()));
        end
        en_last = n;
      end
      if (n <= 16 && (LCD_RS !== v.rs || LCD_DATA !== v.data)) held_ok = 1'b0;
      if (LCD_RW !== 1'b0) held_ok = 1'b0;
      if (cmd_ready) begin
        first_rdy = n;
        break;
      end
    end
    check({tag, "_latency"},  32'(first_rdy), 32'(v.exp_lat));
    check({tag, "_en_first"}, 32'(en_first),  32'd3);
    check({tag, "_en_last"},  32'(en_last),   32'd14);
    check({tag, "_en_count"}, 32'(en_cnt),    32'd12);
    check({tag, "_held"},     32'(held_ok),   32'd1);
  endtask

  vec_t vecs[9];

  // ---------------- main sequence ----------------
  initial begin
    int  rdy_at;
    bit  held_ok;
    vecs[0] = '{rs: 1'b1, data: 8'h41, exp_lat: LAT_N};
    vecs[1] = '{rs: 1'b0, data: 8'h01, exp_lat: LAT_S};
    vecs[2] = '{rs: 1'b1, data: 8'h01, exp_lat: LAT_N};
    vecs[3] = '{rs: 1'b0, data: 8'h02, exp_lat: LAT_S};
    vecs[4] = '{rs: 1'b0, data: 8'h03, exp_lat: LAT_S};
    vecs[5] = '{rs: 1'b0, data: 8'h04, exp_lat: LAT_N};
    vecs[6] = '{rs: 1'b0, data: 8'h00, exp_lat: LAT_N};
    vecs[7] = '{rs: 1'b1, data: 8'h03, exp_lat: LAT_N};
    vecs[8] = '{rs: 1'b0, data: 8'h38, exp_lat: LAT_N};

    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_rs    = 1'b0;
    cmd_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    reset_n = 1'b1;
    check_powerup("pwr");

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Valid held with changing data during the write: the first byte must
    // stay on the bus and the next byte is taken only when ready returns.
    wait_ready("hold");
    cmd_valid = 1'b1;
    cmd_rs    = 1'b1;
    cmd_data  = 8'h55;
    rdy_at    = -1;
    held_ok   = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (cmd_ready) begin
        rdy_at = n;
        break;
      end
      if (n <= 16 && (LCD_DATA !== 8'h55 || LCD_RS !== 1'b1)) held_ok = 1'b0;
      cmd_data = 8'($urandom_range(0, 255));
      cmd_rs   = 1'($urandom_range(0, 1));
    end
    check("hold_bus_stable", 32'(held_ok), 32'd1);
    check("hold_ready_cycle", 32'(rdy_at), 32'(LAT_N));
    cmd_rs   = 1'b1;
    cmd_data = 8'h66;
    @(negedge clk);
    check("hold_second_data", 32'(LCD_DATA), 32'h66);
    check("hold_second_taken", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;

    // Reset in the middle of the enable pulse.
    wait_ready("rstp");
    cmd_valid = 1'b1;
    cmd_rs    = 1'b1;
    cmd_data  = 8'h5A;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);  // now in cycle 6 after accept
    check("rstp_en_before", 32'(LCD_EN), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("rstp");
    @(negedge clk);
    reset_n = 1'b1;
    check_powerup("rstp_pwr");

    run_vec(vecs[0], 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_writer.md
LCD_WRITER -- requirements
Module: lcd_writer

Interface
REQ-001 SHALL have parameter T_SETUP, default 2: clk cycles from RS/DATA valid to LCD_EN rise.
REQ-002 SHALL have parameter T_EN, default 12: clk cycles LCD_EN is held high.
REQ-003 SHALL have parameter T_HOLD, default 2: clk cycles RS/DATA are held after LCD_EN falls.
REQ-004 SHALL have parameter T_CMD, default 2000: settle cycles after a normal command (40 us at 50 MHz).
REQ-005 SHALL have parameter T_SLOW, default 82000: settle cycles after clear/home (1.64 ms).
REQ-006 SHALL have parameter T_PWR, default 750000: power-up wait cycles (15 ms).
REQ-007 SHALL have port clk, input, 1: single clock, 50 MHz CLOCK_50 domain.
REQ-008 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-009 SHALL have port cmd_valid, input, 1: request to write one byte.
REQ-010 SHALL have port cmd_rs, input, 1: 0 = instruction, 1 = character data.
REQ-011 SHALL have port cmd_data, input, 8: byte to write.
REQ-012 SHALL have port cmd_ready, output, 1: block can accept a byte this cycle.
REQ-013 SHALL have port init_done, output, 1: power-up (and init) sequence complete.
REQ-014 SHALL have port LCD_EN, output, 1: LCD enable strobe.
REQ-015 SHALL have port LCD_RS, output, 1: LCD register select.
REQ-016 SHALL have port LCD_RW, output, 1: LCD read/write; tied 0 (write-only).
REQ-017 SHALL have port LCD_DATA, output, 8: LCD data bus, always driven.

Function
REQ-018 SHALL implement states PWRUP, INIT, IDLE, SETUP, PULSE, HOLD, WAIT.
REQ-019 PWRUP SHALL count T_PWR cycles, then go to INIT (macro on) or IDLE (macro off).
REQ-020 cmd_ready SHALL be 1 only in IDLE; a byte is accepted on the cycle cmd_valid & cmd_ready.
REQ-021 On accept, LCD_RS/LCD_DATA SHALL be registered next cycle, held constant through SETUP, PULSE, HOLD; cmd_ready drops the cycle after accept.
REQ-022 SETUP SHALL last T_SETUP cycles, PULSE T_EN cycles with LCD_EN=1, HOLD T_HOLD cycles with LCD_EN=0.
REQ-023 WAIT SHALL last T_SLOW when accepted byte has rs=0 and data in {0x01,0x02,0x03}, else T_CMD; then return to IDLE.
REQ-024 Accept-to-next-ready latency SHALL be exactly 1+T_SETUP+T_EN+T_HOLD+wait cycles.
REQ-025 cmd_valid outside IDLE SHALL be ignored; no buffering, no byte lost if requester holds valid until ready.
REQ-026 A single 20-bit down-counter SHALL time every state; load on state entry, transition at count 0; no wrap-around.
REQ-027 init_done SHALL rise on first entry to IDLE and stay 1 until reset.
REQ-028 LCD_RW SHALL be constant 0 in every state.

Reset
REQ-029 Asserting reset_n low SHALL immediately force PWRUP, LCD_EN=0, LCD_RS=0, LCD_DATA=0x00, cmd_ready=0, init_done=0, counter=T_PWR.
REQ-030 Reset mid-pulse SHALL drop LCD_EN asynchronously; full power-up wait SHALL repeat after release.

Configuration
REQ-031 With MDA_LCD_INIT_EN defined, INIT SHALL write 0x38, 0x0C, 0x01, 0x06 (rs=0) via the same SETUP/PULSE/HOLD/WAIT path (0x01 uses T_SLOW) before IDLE.
REQ-032 Without MDA_LCD_INIT_EN, INIT SHALL not exist; PWRUP goes directly to IDLE and software performs init.

Structure
REQ-033 State enum, default timing constants, slow-command codes and the 4-entry init table SHALL live in package mda_lcd_pkg.
REQ-034 SHALL be a single module; no sub-module (counter and FSM are one process pair).

Verification
REQ-035 Reset release, macro off -> cmd_ready=0, init_done=0 for 750000 cycles, then both 1.
REQ-036 Macro on -> LCD_DATA shows 0x38,0x0C,0x01,0x06 with RS=0, each with one 12-cycle EN pulse; init_done after 3*(17+2000)+(17+82000)+750000 cycles.
REQ-037 Accept rs=1 data=0x41 -> LCD_RS=1, LCD_DATA=0x41, EN high cycles 3..14 after accept, cmd_ready again at cycle 2017.
REQ-038 Accept rs=0 data=0x01 -> cmd_ready again at cycle 82017; rs=1 data=0x01 -> cycle 2017.
REQ-039 cmd_valid held high with changing data during PULSE -> LCD_DATA unchanged, second byte accepted only at next ready.
REQ-040 reset_n low during PULSE -> LCD_EN=0 same cycle, all outputs at reset values, power-up wait restarts.
